// File: rtl/stream_pkt_ctrl_pkg.sv
// Shared types and register map for the stream packet run controller.
// Also holds the packet-size clamp shared by the control path.
package stream_pkt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2
    } state_e;

    // System-bus register offsets of the cfg/status fields
    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_PKT_SIZE = 8'h04;
    localparam logic [7:0] REG_NUM_PKTS = 8'h08;
    localparam logic [7:0] REG_TIMEOUT  = 8'h0C;
    localparam logic [7:0] REG_STATUS   = 8'h10;
    localparam logic [7:0] REG_BEAT_CNT = 8'h14;
    localparam logic [7:0] REG_PKT_CNT  = 8'h18;
    localparam logic [7:0] REG_PAD_CNT  = 8'h1C;

    function automatic logic [31:0] clamp_size(input logic [31:0] size);
        return (size == 32'd0) ? 32'd1 : size;
    endfunction

endpackage

// File: rtl/stream_idle_timer.sv
// Saturating idle-cycle counter; hit flags the cycle the count reaches threshold-1.
// A zero threshold disables the hit output.
module stream_idle_timer
    import stream_pkt_ctrl_pkg::*;
#(
    parameter int TO_W = 24
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] threshold,
    output logic            hit
);

    logic [TO_W-1:0] cnt_r;

    // Count enabled idle cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != '1)) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign hit = en && (threshold != '0) && (cnt_r == (threshold - TO_W'(1)));

endmodule

// File: rtl/stream_pkt_ctrl.sv
// Run controller between the trigger-capture FWFT FIFO and the AXI-stream DMA FIFO.
// Frames words into packets, pad-closes stalled packets, and counts beats/packets/pads.
module stream_pkt_ctrl
    import stream_pkt_ctrl_pkg::*;
#(
    parameter int               DATA_W   = 64,
    parameter int               TO_W     = 24,
    parameter logic [DATA_W-1:0] PAD_WORD = {DATA_W{1'b1}}
) (
    input  logic                clk,
    input  logic                rstn_i,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic [31:0]         cfg_packet_size,
    input  logic [15:0]         cfg_num_packets,
    input  logic [TO_W-1:0]     cfg_timeout,
    input  logic [DATA_W-1:0]   src_data,
    input  logic                src_empty,
    output logic                src_rd_en,
    output logic [DATA_W-1:0]   m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                busy,
    output logic                done,
    output logic [31:0]         beat_cnt,
    output logic [31:0]         pkt_cnt,
    output logic [15:0]         pad_cnt
);

    state_e          state_r, state_nxt_s;
    logic [31:0]     size_r;
    logic [15:0]     num_r;
    logic [TO_W-1:0] to_r;
    logic            stop_pend_r, done_r;
    logic [31:0]     beat_cnt_r, pkt_cnt_r;
    logic [15:0]     pad_cnt_r;
    logic            beat_s, last_s, run_end_s, timeout_s, idle_en_s;
    logic            end_run_s, stop_set_s, start_s;

    assign start_s   = (state_r == ST_IDLE) && cfg_start;
    assign last_s    = (beat_cnt_r == (size_r - 32'd1));
    assign beat_s    = m_tvalid && m_tready;
    assign run_end_s = (num_r != 16'd0) && ((pkt_cnt_r + 32'd1) == {16'd0, num_r});
    assign idle_en_s = (state_r == ST_RUN) && (beat_cnt_r != 32'd0) && src_empty;

    stream_idle_timer #(.TO_W(TO_W)) u_idle_timer (
        .clk       (clk),
        .rstn_i    (rstn_i),
        .clr       (!idle_en_s),
        .en        (idle_en_s),
        .threshold (to_r),
        .hit       (timeout_s)
    );

    // Stream datapath: zero-latency pass-through in RUN, constant pad beat in PAD
    always_comb begin
        m_tdata   = src_data;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        src_rd_en = 1'b0;
        case (state_r)
            ST_RUN: begin
                m_tvalid  = !src_empty;
                m_tlast   = last_s;
                src_rd_en = m_tready && !src_empty;
            end
            ST_PAD: begin
                m_tdata  = PAD_WORD;
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
            end
            default: begin
                m_tvalid = 1'b0;
            end
        endcase
    end

    // Next state; a closing tlast beat always wins over stop/timeout handling
    always_comb begin
        state_nxt_s = state_r;
        end_run_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (beat_s && last_s && (run_end_s || cfg_stop || stop_pend_r)) begin
                    state_nxt_s = ST_IDLE;
                    end_run_s   = 1'b1;
                end else if (cfg_stop && (beat_cnt_r == 32'd0) && !beat_s) begin
                    state_nxt_s = ST_IDLE;
                    end_run_s   = 1'b1;
                end else if ((stop_pend_r && !beat_s) || timeout_s) begin
                    state_nxt_s = ST_PAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAD: begin
                if (beat_s && (stop_pend_r || cfg_stop || run_end_s)) begin
                    state_nxt_s = ST_IDLE;
                    end_run_s   = 1'b1;
                end else if (beat_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign stop_set_s = cfg_stop && (state_r != ST_IDLE) && !end_run_s;

    // State register
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Run configuration latched on an accepted start
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            size_r <= 32'd0;
            num_r  <= 16'd0;
            to_r   <= '0;
        end else if (start_s) begin
            size_r <= clamp_size(cfg_packet_size);
            num_r  <= cfg_num_packets;
            to_r   <= cfg_timeout;
        end
    end

    // Beat, packet and pad counters plus run status flags
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            beat_cnt_r  <= 32'd0;
            pkt_cnt_r   <= 32'd0;
            pad_cnt_r   <= 16'd0;
            stop_pend_r <= 1'b0;
            done_r      <= 1'b0;
        end else if (start_s) begin
            beat_cnt_r  <= 32'd0;
            pkt_cnt_r   <= 32'd0;
            pad_cnt_r   <= 16'd0;
            stop_pend_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (beat_s && m_tlast) begin
                beat_cnt_r <= 32'd0;
                pkt_cnt_r  <= pkt_cnt_r + 32'd1;
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + 32'd1;
            end
            if (beat_s && (state_r == ST_PAD) && (pad_cnt_r != 16'hFFFF)) begin
                pad_cnt_r <= pad_cnt_r + 16'd1;
            end
            if (end_run_s) begin
                done_r      <= 1'b1;
                stop_pend_r <= 1'b0;
            end else if (stop_set_s) begin
                stop_pend_r <= 1'b1;
            end
        end
    end

    assign m_tkeep  = {(DATA_W/8){1'b1}};
    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;
    assign beat_cnt = beat_cnt_r;
    assign pkt_cnt  = pkt_cnt_r;
    assign pad_cnt  = pad_cnt_r;

endmodule
